// File: rtl/minbd_pkg.sv
// Shared types and defaults for the MinBD router side buffer.
package minbd_pkg;

  localparam int FLIT_W_DEFAULT    = 64;
  localparam int DEPTH_DEFAULT     = 4;
  localparam int STARVE_TH_DEFAULT = 2;

  typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

  typedef enum logic [1:0] {
    SB_EMPTY    = 2'd0,
    SB_WAIT     = 2'd1,
    SB_REDIRECT = 2'd2
  } sb_state_t;

endpackage

// File: rtl/side_buffer_if.sv
// Flit ingress/egress bundle for the side buffer; master is the router pipeline.
interface side_buffer_if #(
  parameter int FLIT_W = minbd_pkg::FLIT_W_DEFAULT,
  parameter int DEPTH  = minbd_pkg::DEPTH_DEFAULT
);
  import minbd_pkg::*;

  logic                         in_valid;
  logic [FLIT_W-1:0]            in_flit;
  logic                         in_ready;
  logic                         out_valid;
  logic [FLIT_W-1:0]            out_flit;
  logic                         out_grant;
  logic                         slot_free;
  logic                         redirect_req;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow_err;
  sb_state_t                    state;

  modport master (
    output in_valid, in_flit, out_grant, slot_free,
    input  in_ready, out_valid, out_flit, redirect_req, count, overflow_err, state
  );

  modport slave (
    input  in_valid, in_flit, out_grant, slot_free,
    output in_ready, out_valid, out_flit, redirect_req, count, overflow_err, state
  );

endinterface

// File: rtl/side_buffer_starve_ctr.sv
// Head-of-line aging FSM: requests a forced slot once the head has waited STARVE_TH cycles.
module side_buffer_starve_ctr #(
  parameter int STARVE_TH = minbd_pkg::STARVE_TH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 occupied_i,
  input  logic                 pop_i,
  output logic                 redirect_req_o,
  output minbd_pkg::sb_state_t state_o
);
  import minbd_pkg::*;

  localparam logic [7:0] TH = 8'(STARVE_TH);

  sb_state_t  state_q;
  logic       redirect_req_q;
  logic [7:0] starve_cnt_q;
  logic [7:0] starve_inc_s;

  assign starve_inc_s   = (starve_cnt_q == 8'hFF) ? 8'hFF : starve_cnt_q + 8'd1;
  assign redirect_req_o = redirect_req_q;
  assign state_o        = state_q;

  // occupied_i is the post-edge occupancy, so a drain-with-refill keeps the FSM in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= SB_EMPTY;
      redirect_req_q <= 1'b0;
      starve_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          starve_cnt_q   <= 8'd0;
          redirect_req_q <= 1'b0;
          state_q        <= occupied_i ? SB_WAIT : SB_EMPTY;
        end
        SB_WAIT: begin
          if (pop_i) begin
            starve_cnt_q   <= 8'd0;
            redirect_req_q <= 1'b0;
            state_q        <= occupied_i ? SB_WAIT : SB_EMPTY;
          end else if (starve_inc_s >= TH) begin
            starve_cnt_q   <= TH;
            redirect_req_q <= 1'b1;
            state_q        <= SB_REDIRECT;
          end else begin
            starve_cnt_q   <= starve_inc_s;
            redirect_req_q <= 1'b0;
            state_q        <= SB_WAIT;
          end
        end
        SB_REDIRECT: begin
          if (pop_i) begin
            starve_cnt_q   <= 8'd0;
            redirect_req_q <= 1'b0;
            state_q        <= occupied_i ? SB_WAIT : SB_EMPTY;
          end else begin
            starve_cnt_q   <= TH;
            redirect_req_q <= 1'b1;
            state_q        <= SB_REDIRECT;
          end
        end
        default: begin
          starve_cnt_q   <= 8'd0;
          redirect_req_q <= 1'b0;
          state_q        <= SB_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/side_buffer.sv
// Deflection side buffer: small FIFO of deflected flits offered back for reinjection.
module side_buffer #(
  parameter int FLIT_W    = minbd_pkg::FLIT_W_DEFAULT,
  parameter int DEPTH     = minbd_pkg::DEPTH_DEFAULT,
  parameter int STARVE_TH = minbd_pkg::STARVE_TH_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  side_buffer_if.slave sb
);
  import minbd_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full_s, empty_s, push_s, pop_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == {CW{1'b0}});
  assign push_s  = sb.in_valid && !full_s;
  assign pop_s   = sb.out_grant && !empty_s;

  assign sb.in_ready     = !full_s;
  assign sb.out_valid    = !empty_s;
  assign sb.out_flit     = empty_s ? {FLIT_W{1'b0}} : mem_q[rd_ptr_q];
  assign sb.count        = count_q;
  assign sb.overflow_err = overflow_q;

  // Next-state pointers, occupancy and sticky overflow; wrap by compare for any DEPTH.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (sb.in_valid && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Flit storage carries no reset; out_flit is gated while empty instead.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= sb.in_flit;
    end
  end

  side_buffer_starve_ctr #(.STARVE_TH(STARVE_TH)) u_starve (
    .clk            (clk),
    .reset          (reset),
    .occupied_i     (count_d != {CW{1'b0}}),
    .pop_i          (pop_s),
    .redirect_req_o (sb.redirect_req),
    .state_o        (sb.state)
  );

endmodule
